// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: FSM state encoding and
// default parameter values used by uart_tx_fifo and sync_fifo.
package uart_pkg;

    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_ACT_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACT = 2'd2,
        BUSY     = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level/empty/full flags.
// Push while full and pop while empty are ignored internally, so callers may
// present raw requests. Depth must be a power of two so the pointers wrap
// naturally modulo depth.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int width = DEF_DATA_BITS,
    parameter int depth = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [width-1:0]       wr_data,
    output logic [width-1:0]       rd_data,
    output logic [$clog2(depth):0] level,
    output logic                   empty,
    output logic                   full
);

    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [lw-1:0]    next_level;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this edge; flags are derived from it so all three agree.
    always_comb begin
        next_level = level + lw'(do_push) - lw'(do_pop);
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            level <= next_level;
            empty <= (next_level == '0);
            full  <= (next_level == lw'(depth));
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side FIFO feeding a UART transmitter. Characters are popped one at a
// time into a holding register, launched with a single-cycle strobe, and the
// transmitter's busy signal is then tracked so the next launch waits for the
// current frame to finish. A missing busy response raises a sticky error.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int data_bits   = DEF_DATA_BITS,
    parameter int depth       = DEF_DEPTH,
    parameter int act_timeout = DEF_ACT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [data_bits-1:0]   in_data,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [data_bits-1:0]   tx_data_in,
    output logic                   tx_data_vld,
    input  logic                   tx_active,
    output logic [$clog2(depth):0] fifo_level,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic                   overflow,
    output logic                   tx_err
);

    localparam int cw = (act_timeout < 2) ? 1 : $clog2(act_timeout);
    localparam logic [cw-1:0] cnt_last = cw'(act_timeout - 1);

    tx_state_t            state;
    logic [cw-1:0]        cnt;
    logic                 push;
    logic                 pop;
    logic [data_bits-1:0] head;

    assign in_rdy = !fifo_full;
    assign push   = in_vld && in_rdy;
    assign pop    = (state == IDLE) && !fifo_empty && !tx_active;

    // The strobe comes from the registered state; it is also masked by
    // tx_active so a transmitter that is already busy never sees a launch.
    assign tx_data_vld = (state == SEND) && !tx_active;

    sync_fifo #(
        .width (data_bits),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Sticky flag for a character offered while the FIFO had no room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_vld && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Launch FSM: pop head, strobe, wait for busy to rise, wait for it to fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_data_in <= '0;
            cnt        <= '0;
            tx_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= SEND;
                        tx_data_in <= head;
                    end
                end
                SEND: begin
                    state <= WAIT_ACT;
                    cnt   <= '0;
                end
                WAIT_ACT: begin
                    if (tx_active) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end else if (cnt == cnt_last) begin
                        state  <= IDLE;
                        tx_err <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                BUSY: begin
                    if (!tx_active) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo. Accepted characters are queued by the
// stimulus side; a monitor pops the queue on every launch strobe. A small
// transmitter model answers strobes with a busy pulse of programmable length.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] tx_data_in;
    logic       tx_data_vld;
    logic       tx_active;
    logic [4:0] fifo_level;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic       tx_err;

    logic       tx_frame;
    logic       force_busy;
    logic       respond;
    int         frame_len;

    logic [7:0] sb_q [$];
    int         total_checks;
    int         bad_checks;
    int         strobes;
    int         accepted;
    int         discarded;

    assign tx_active = tx_frame | force_busy;

    uart_tx_fifo #(
        .data_bits   (8),
        .depth       (16),
        .act_timeout (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .tx_data_in  (tx_data_in),
        .tx_data_vld (tx_data_vld),
        .tx_active   (tx_active),
        .fifo_level  (fifo_level),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one character; the bench decides whether it must be accepted.
    task automatic applyStimulus(input logic [7:0] d, input bit expect_acc);
        @(negedge clk);
        in_data = d;
        in_vld  = 1'b1;
        if (expect_acc) checkOutput("in_rdy_high", 32'(in_rdy), 32'd1);
        else            checkOutput("in_rdy_low", 32'(in_rdy), 32'd0);
        @(posedge clk);
        if (expect_acc) begin
            sb_q.push_back(d);
            accepted++;
        end
        #1 in_vld = 1'b0;
    endtask

    // Wait until nothing is queued and the transmitter has been quiet a while.
    task automatic waitDrain(input int max_cycles);
        int n = 0;
        int quiet = 0;
        while (quiet < 6 && n < max_cycles) begin
            @(negedge clk);
            n++;
            if (sb_q.size() == 0 && !tx_active && !tx_data_vld) quiet++;
            else quiet = 0;
        end
        checkOutput("drain_in_time", 32'(n < max_cycles), 32'd1);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_empty", 32'(fifo_empty), 32'd1);
        checkOutput("rst_full", 32'(fifo_full), 32'd0);
        checkOutput("rst_in_rdy", 32'(in_rdy), 32'd1);
        checkOutput("rst_vld", 32'(tx_data_vld), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data_in), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_tx_err", 32'(tx_err), 32'd0);
    endtask

    // Transmitter model: busy pulse starting the edge after a strobe.
    initial begin
        tx_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_vld && respond) begin
                @(posedge clk);
                #1 tx_frame = 1'b1;
                repeat (frame_len) @(posedge clk);
                #1 tx_frame = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the oldest accepted character.
    initial begin
        logic       prev_vld;
        logic [7:0] exp;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
            end else begin
                checkOutput("flag_empty", 32'(fifo_empty), 32'(fifo_level == 5'd0));
                checkOutput("flag_full", 32'(fifo_full), 32'(fifo_level == 5'd16));
                checkOutput("flag_in_rdy", 32'(in_rdy), 32'(!fifo_full));
                if (tx_data_vld) begin
                    strobes++;
                    checkOutput("strobe_while_active", 32'(tx_active), 32'd0);
                    checkOutput("strobe_one_cycle", 32'(prev_vld), 32'd0);
                    if (sb_q.size() == 0) begin
                        total_checks++;
                        bad_checks++;
                        $display("[TB] FAIL unexpected_strobe: got %0h expected none at %0t", tx_data_in, $time);
                    end else begin
                        exp = sb_q.pop_front();
                        checkOutput("tx_data_order", 32'(tx_data_in), 32'(exp));
                    end
                end
                prev_vld = tx_data_vld;
            end
        end
    end

    // Global bound so the run always ends.
    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int s0;
        total_checks = 0;
        bad_checks   = 0;
        strobes      = 0;
        accepted     = 0;
        discarded    = 0;
        force_busy   = 1'b0;
        respond      = 1'b1;
        frame_len    = 10;
        in_data      = 8'hFF;
        in_vld       = 1'b1;
        rst          = 1'b1;

        // Reset with in_vld held: must be ignored, no overflow.
        repeat (3) @(posedge clk);
        #1;
        checkResetValues();
        rst    = 1'b0;
        in_vld = 1'b0;

        // Single character and launch latency.
        applyStimulus(8'hA5, 1'b1);
        checkOutput("latency_early", 32'(tx_data_vld), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_strobe", 32'(tx_data_vld), 32'd1);
        checkOutput("latency_data", 32'(tx_data_in), 32'hA5);
        waitDrain(100);

        // Burst fill to full, then overflow attempts, then drain in order.
        @(negedge clk);
        force_busy = 1'b1;
        for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b1);
        checkOutput("burst_full", 32'(fifo_full), 32'd1);
        checkOutput("burst_level", 32'(fifo_level), 32'd16);
        checkOutput("burst_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("burst_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 1'b0);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_level", 32'(fifo_level), 32'd16);
        s0 = strobes;
        @(negedge clk);
        force_busy = 1'b0;
        waitDrain(600);
        checkOutput("burst_strobes", 32'(strobes - s0), 32'd16);

        // Simultaneous push and pop at level 5.
        @(negedge clk);
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h21 + i), 1'b1);
        checkOutput("pp_level_before", 32'(fifo_level), 32'd5);
        @(negedge clk);
        force_busy = 1'b0;
        in_data    = 8'h26;
        in_vld     = 1'b1;
        checkOutput("pp_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        sb_q.push_back(8'h26);
        accepted++;
        #1 in_vld = 1'b0;
        checkOutput("pp_level_after", 32'(fifo_level), 32'd5);
        frame_len = 3;
        waitDrain(300);

        // Transmitter never answers: error after the timeout, next char still goes.
        @(negedge clk);
        force_busy = 1'b1;
        respond    = 1'b0;
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h7E, 1'b1);
        @(negedge clk);
        force_busy = 1'b0;
        n = 0;
        while (!tx_data_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_first_strobe", 32'(n < 20), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("to_err_not_yet", 32'(tx_err), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("to_err_set", 32'(tx_err), 32'd1);
        n = 0;
        s0 = strobes;
        while (strobes == s0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_next_launch", 32'(strobes - s0), 32'd1);
        waitDrain(100);
        respond = 1'b1;

        // Reset while a long frame is in progress with three characters queued.
        frame_len = 40;
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h51 + i), 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("mid_busy_active", 32'(tx_active), 32'd1);
        checkOutput("mid_busy_level", 32'(fifo_level), 32'd3);
        @(negedge clk);
        rst    = 1'b1;
        in_vld = 1'b1;
        in_data = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        in_vld = 1'b0;
        discarded += sb_q.size();
        sb_q.delete();
        checkResetValues();
        s0 = strobes;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_rst_no_strobe", 32'(strobes - s0), 32'd0);
        frame_len = 3;
        applyStimulus(8'h99, 1'b1);
        waitDrain(200);
        checkOutput("post_rst_launch", 32'(strobes - s0), 32'd1);

        // Randomised traffic with random frame lengths and gaps.
        for (int i = 0; i < 40; i++) begin
            frame_len = int'($urandom_range(1, 4));
            if (sb_q.size() < 16) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
            else @(posedge clk);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
        end
        waitDrain(1500);

        checkOutput("launch_count", 32'(strobes), 32'(accepted - discarded));
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
